// File: rtl/display_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : display_timing_gen_pkg
// Brief  : Default display timing constants, totals and horizontal phase type.
// Rev    : 1.0  initial release
// ============================================================================
package display_timing_gen_pkg;

    localparam int c_cnt_w           = 11;

    localparam int c_def_h_visible   = 1024;
    localparam int c_def_h_fp        = 24;
    localparam int c_def_h_sync      = 136;
    localparam int c_def_h_bp        = 160;
    localparam int c_def_v_visible   = 768;
    localparam int c_def_v_fp        = 3;
    localparam int c_def_v_sync      = 6;
    localparam int c_def_v_bp        = 29;

    typedef enum logic [1:0] {
        PH_VISIBLE = 2'd0,
        PH_FRONT   = 2'd1,
        PH_SYNC    = 2'd2,
        PH_BACK    = 2'd3
    } h_phase_t;

    function automatic int timing_total(input int vis, input int fp, input int sync, input int bp);
        return vis + fp + sync + bp;
    endfunction

    // Phase a given column belongs to; used to cross-check the phase FSM.
    function automatic h_phase_t h_phase_of(input logic [c_cnt_w-1:0] col,
                                            input logic [c_cnt_w-1:0] vis,
                                            input logic [c_cnt_w-1:0] sync_start,
                                            input logic [c_cnt_w-1:0] sync_end);
        if (col < vis)             return PH_VISIBLE;
        else if (col < sync_start) return PH_FRONT;
        else if (col < sync_end)   return PH_SYNC;
        else                       return PH_BACK;
    endfunction

    localparam int c_def_h_total = timing_total(c_def_h_visible, c_def_h_fp, c_def_h_sync, c_def_h_bp);
    localparam int c_def_v_total = timing_total(c_def_v_visible, c_def_v_fp, c_def_v_sync, c_def_v_bp);

endpackage
`default_nettype wire

// File: rtl/display_timing_gen_sync_delay_line.sv
`default_nettype none
// ============================================================================
// Module : sync_delay_line
// Brief  : Resettable shift register of configurable depth; depth 0 passes through.
// Rev    : 1.0  initial release
// ============================================================================
module sync_delay_line
    import display_timing_gen_pkg::*;
#(
    parameter int                 DEPTH     = 1,
    parameter int                 WIDTH     = 3,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused;
        assign w_unused = clk ^ reset;
        assign q        = d;
    end else begin : g_chain
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) r_stage[i] <= RESET_VAL;
            end else begin
                r_stage[0] <= d;
                for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign q = r_stage[DEPTH-1];
    end

endmodule
`default_nettype wire

// File: rtl/display_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : display_timing_gen
// Brief  : Pixel/line counters, registered coordinates, sync and blank timing.
// Rev    : 1.0  initial release
// ============================================================================
module display_timing_gen
    import display_timing_gen_pkg::*;
#(
    parameter int H_VISIBLE  = c_def_h_visible,
    parameter int H_FP       = c_def_h_fp,
    parameter int H_SYNC     = c_def_h_sync,
    parameter int H_BP       = c_def_h_bp,
    parameter int V_VISIBLE  = c_def_v_visible,
    parameter int V_FP       = c_def_v_fp,
    parameter int V_SYNC     = c_def_v_sync,
    parameter int V_BP       = c_def_v_bp,
    parameter int SYNC_POL   = 0,
    parameter int PIPE_DELAY = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic signed [31:0] pixel_column,
    output logic signed [31:0] pixel_row,
    output logic               video_on,
    output logic               horiz_sync,
    output logic               vert_sync,
    output logic               frame_start
);

    localparam int c_h_total = timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int c_v_total = timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1
        || H_VISIBLE < 1 || V_VISIBLE < 1
        || c_h_total > (1 << c_cnt_w) || c_v_total > (1 << c_cnt_w)
        || PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_params
        $error("display_timing_gen: illegal timing parameters");
    end

    localparam logic [c_cnt_w-1:0] c_h_last   = c_cnt_w'(c_h_total - 1);
    localparam logic [c_cnt_w-1:0] c_v_last   = c_cnt_w'(c_v_total - 1);
    localparam logic [c_cnt_w-1:0] c_h_vis    = c_cnt_w'(H_VISIBLE);
    localparam logic [c_cnt_w-1:0] c_hs_start = c_cnt_w'(H_VISIBLE + H_FP);
    localparam logic [c_cnt_w-1:0] c_hs_end   = c_cnt_w'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [c_cnt_w-1:0] c_v_vis    = c_cnt_w'(V_VISIBLE);
    localparam logic [c_cnt_w-1:0] c_vs_start = c_cnt_w'(V_VISIBLE + V_FP);
    localparam logic [c_cnt_w-1:0] c_vs_end   = c_cnt_w'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic               c_pol      = (SYNC_POL != 0);
    localparam logic [2:0]         c_idle     = {1'b0, ~c_pol, ~c_pol};

    logic [c_cnt_w-1:0] r_h_cnt, r_v_cnt, r_col, r_row;
    logic               r_primed, r_upd, r_frame_start;
    logic [2:0]         r_raw;
    h_phase_t           r_phase;
    logic               w_vid, w_hs, w_vs;
    logic [2:0]         w_delayed;

    assign w_vid = (r_col < c_h_vis) && (r_row < c_v_vis);
    assign w_hs  = ((r_col >= c_hs_start) && (r_col < c_hs_end)) ? c_pol : ~c_pol;
    assign w_vs  = ((r_row >= c_vs_start) && (r_row < c_vs_end)) ? c_pol : ~c_pol;

    // The first enabled cycle after reset only arms the counters, so (0,0)
    // is emitted as a fresh position together with frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_primed      <= 1'b0;
            r_upd         <= 1'b0;
            r_frame_start <= 1'b0;
            r_raw         <= c_idle;
        end else begin
            r_upd <= pix_en;
            if (pix_en) begin
                if (!r_primed) begin
                    r_primed <= 1'b1;
                end else if (r_h_cnt == c_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= (r_v_cnt == c_v_last) ? '0 : r_v_cnt + c_cnt_w'(1);
                end else begin
                    r_h_cnt <= r_h_cnt + c_cnt_w'(1);
                end
            end
            r_col         <= r_h_cnt;
            r_row         <= r_v_cnt;
            r_frame_start <= r_upd && (r_h_cnt == '0) && (r_v_cnt == '0);
            r_raw         <= {w_vid, w_hs, w_vs};
        end
    end

    // Horizontal phase follows the value being loaded into r_col.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PH_VISIBLE;
        end else begin
            case (r_phase)
                PH_VISIBLE: if (r_h_cnt == c_h_vis)    r_phase <= PH_FRONT;
                PH_FRONT:   if (r_h_cnt == c_hs_start) r_phase <= PH_SYNC;
                PH_SYNC:    if (r_h_cnt == c_hs_end)   r_phase <= PH_BACK;
                PH_BACK:    if (r_h_cnt == '0)         r_phase <= PH_VISIBLE;
                default:                               r_phase <= PH_VISIBLE;
            endcase
        end
    end

    a_phase_matches_decode: assert property (@(posedge clk) disable iff (reset)
        r_phase == h_phase_of(r_col, c_h_vis, c_hs_start, c_hs_end));

    sync_delay_line #(
        .DEPTH     (PIPE_DELAY),
        .WIDTH     (3),
        .RESET_VAL (c_idle)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .d     (r_raw),
        .q     (w_delayed)
    );

    assign {video_on, horiz_sync, vert_sync} = w_delayed;
    assign pixel_column = {{(32-c_cnt_w){1'b0}}, r_col};
    assign pixel_row    = {{(32-c_cnt_w){1'b0}}, r_row};
    assign frame_start  = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_display_timing_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_display_timing_gen
// Brief  : Directed self-checking bench on a reduced timing (25x10 frame).
// Rev    : 1.0  initial release
// ============================================================================
module tb_display_timing_gen;

    localparam int HV = 16, HF = 2, HS = 3, HB = 4;
    localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;   // 25
    localparam int VT = VV + VF + VS + VB;   // 10
    localparam int FT = HT * VT;             // 250

    logic clk = 1'b0;
    logic reset, pix_en;
    logic signed [31:0] col_a, row_a, col_b, row_b;
    logic vid_a, hs_a, vs_a, fs_a;
    logic vid_b, hs_b, vs_b, fs_b;

    int checks = 0;
    int errors = 0;
    int fs_seen;

    always #5 clk = ~clk;

    display_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(0), .PIPE_DELAY(1)
    ) dut_a (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .pixel_column(col_a), .pixel_row(row_a),
        .video_on(vid_a), .horiz_sync(hs_a), .vert_sync(vs_a), .frame_start(fs_a)
    );

    display_timing_gen #(
        .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1), .PIPE_DELAY(0)
    ) dut_b (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .pixel_column(col_b), .pixel_row(row_b),
        .video_on(vid_b), .horiz_sync(hs_b), .vert_sync(vs_b), .frame_start(fs_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Linear pixel index shown after edge n counted from the last reset edge.
    // mode 0: pix_en always 1; mode 1: pix_en = 1,0,1,0,... starting at edge 1.
    function automatic int pos(input int mode, input int n);
        int p;
        p = (mode == 0) ? n - 2 : n / 2 - 1;
        return (p < 0) ? 0 : p;
    endfunction

    // Expected {video_on, hsync, vsync} given the coordinate-index lag.
    function automatic logic [2:0] exp_out(input int mode, input int m, input logic pol);
        int p, c, r;
        logic v, h, s;
        if (m < 1) return {1'b0, ~pol, ~pol};
        p = pos(mode, m - 1);
        c = p % HT;
        r = (p / HT) % VT;
        v = (c < HV) && (r < VV);
        h = (c >= HV + HF && c < HV + HF + HS) ? pol : ~pol;
        s = (r >= VV + VF && r < VV + VF + VS) ? pol : ~pol;
        return {v, h, s};
    endfunction

    task automatic run_seq(input int mode, input int nedges);
        int p;
        logic [2:0] ea, eb;
        logic efs;
        fs_seen = 0;
        for (int n = 1; n <= nedges; n++) begin
            pix_en = (mode == 0) ? 1'b1 : 1'((n % 2) == 1);
            @(posedge clk);
            #1;
            p   = pos(mode, n);
            efs = ((p % FT) == 0) && (n == 2 || p != pos(mode, n - 1));
            ea  = exp_out(mode, n - 1, 1'b0);
            eb  = exp_out(mode, n, 1'b1);
            if (fs_a) fs_seen++;
            check($sformatf("m%0d n%0d col", mode, n), col_a, 32'(p % HT));
            check($sformatf("m%0d n%0d row", mode, n), row_a, 32'((p / HT) % VT));
            check($sformatf("m%0d n%0d fs_a", mode, n), 32'(fs_a), 32'(efs));
            check($sformatf("m%0d n%0d fs_b", mode, n), 32'(fs_b), 32'(efs));
            check($sformatf("m%0d n%0d out_a", mode, n), 32'({vid_a, hs_a, vs_a}), 32'(ea));
            check($sformatf("m%0d n%0d out_b", mode, n), 32'({vid_b, hs_b, vs_b}), 32'(eb));
            check($sformatf("m%0d n%0d col_b", mode, n), col_b, 32'(p % HT));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " col"},  col_a, 0);
        check({tag, " row"},  row_a, 0);
        check({tag, " vid_a"}, 32'(vid_a), 0);
        check({tag, " hs_a"},  32'(hs_a), 1);
        check({tag, " vs_a"},  32'(vs_a), 1);
        check({tag, " fs_a"},  32'(fs_a), 0);
        check({tag, " vid_b"}, 32'(vid_b), 0);
        check({tag, " hs_b"},  32'(hs_b), 0);
        check({tag, " vs_b"},  32'(vs_b), 0);
    endtask

    initial begin
        reset  = 1'b1;
        pix_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("init");

        // Two full frames plus the third frame start, continuous enable.
        reset = 1'b0;
        run_seq(0, 2 * FT + 2);
        check("fs_count", 32'(fs_seen), 3);

        // Reset mid-frame at (10,3), enable still high.
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("rst_end");
        reset = 1'b0;
        run_seq(0, 3 * HT + 12);
        check("pre_mid col", col_a, 10);
        check("pre_mid row", row_a, 3);
        reset  = 1'b1;
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("rst_mid");
        reset = 1'b0;
        run_seq(0, 60);

        // Half-rate enable from a fresh reset.
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_seq(1, 2 * HT + 30);
        check("toggle fs_count", 32'(fs_seen), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_timing_gen.md
DISPLAY_TIMING_GEN -- requirements
Module: display_timing_gen

Interface
REQ-001 Parameter: H_VISIBLE, 1024, active pixels per line.
REQ-002 Parameter: H_FP, 24, horizontal front porch in pixels.
REQ-003 Parameter: H_SYNC, 136, horizontal sync width in pixels.
REQ-004 Parameter: H_BP, 160, horizontal back porch in pixels.
REQ-005 Parameter: V_VISIBLE, 768, active lines per frame.
REQ-006 Parameter: V_FP, 3, vertical front porch in lines.
REQ-007 Parameter: V_SYNC, 6, vertical sync width in lines.
REQ-008 Parameter: V_BP, 29, vertical back porch in lines.
REQ-009 Parameter: SYNC_POL, 0, sync active level (0 = active-low).
REQ-010 Parameter: PIPE_DELAY, 1, extra cycles of sync/video_on delay relative to coordinates, 0..4.
REQ-011 Port: clk, input, 1, system clock.
REQ-012 Port: reset, input, 1, reset, synchronous, active-high; clock clk.
REQ-013 Port: pix_en, input, 1, pixel-rate enable; the timing advances only on cycles where it is 1.
REQ-014 Port: pixel_column, output, 32, signed, current horizontal count, zero-extended.
REQ-015 Port: pixel_row, output, 32, signed, current vertical count, zero-extended.
REQ-016 Port: video_on, output, 1, high inside the visible region (delayed per REQ-023).
REQ-017 Port: horiz_sync, output, 1, horizontal sync (delayed per REQ-023).
REQ-018 Port: vert_sync, output, 1, vertical sync (delayed per REQ-023).
REQ-019 Port: frame_start, output, 1, single-cycle pulse at coordinate (0,0).

Function
REQ-020 H_TOTAL is the sum of H_VISIBLE, H_FP, H_SYNC and H_BP (1344); V_TOTAL is the sum of the vertical terms (806); all counters are 11-bit unsigned.
REQ-021 Counting: on a cycle with pix_en=1, h_cnt increments. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. When h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 on the same enabled cycle, both wrap to 0. With pix_en=0, all state holds.
REQ-022 pixel_column and pixel_row are registered copies of h_cnt and v_cnt, updated one clk after the counter change. They are also valid outside the visible region.
REQ-023 Decode of the registered coordinates:
- video_on_raw = (col<H_VISIBLE) && (row<V_VISIBLE).
- hsync_raw active for H_VISIBLE+H_FP <= col < H_VISIBLE+H_FP+H_SYNC.
- vsync_raw active for V_VISIBLE+V_FP <= row < V_VISIBLE+V_FP+V_SYNC.
- Each of these passes through a PIPE_DELAY-stage register chain that advances on every clk, not only on pix_en, before reaching its port.
- The delay matches the registered colour output of the downstream icon/colour stage.
REQ-024 Active sync level equals SYNC_POL; the inactive level equals the inverse of SYNC_POL.
REQ-025 frame_start is 1 for exactly one clk, on the cycle that pixel_column=0 and pixel_row=0 first become visible after an enabled update. It does not repeat while pix_en=0 holds the position.
REQ-026 Horizontal phase FSM, for monitoring and assertion use:
- States: VISIBLE, FRONT, SYNC, BACK.
- Transitions occur at col = H_VISIBLE, H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC, and H_TOTAL (wrap to VISIBLE).
- The FSM state shall always agree with the REQ-023 decode.
REQ-027 Parameter legality: every porch/sync value is at least 1. Illegal values shall be rejected at elaboration.

Reset
REQ-028 Reset forces:
- h_cnt=0, v_cnt=0, pixel_column=0, pixel_row=0.
- video_on=0, horiz_sync=!SYNC_POL, vert_sync=!SYNC_POL, frame_start=0.
- All delay stages cleared to their inactive values.
- FSM state = VISIBLE.
REQ-029 Reset asserted mid-frame takes effect on the next clk edge regardless of pix_en. After reset release, the first enabled cycle produces coordinate (0,0) with frame_start=1.

Structure
REQ-030 A shared package holds the default timing constants, H_TOTAL/V_TOTAL derivation and the phase enum; the robot icon and colorizer blocks import the same package.
REQ-031 One sub-module, sync_delay_line: a parameterised-depth shift register carrying {video_on, hsync, vsync} with reset to inactive values. A depth of 0 is a pass-through.

Verification
REQ-032 Reset, then pix_en held at 1 for 1344*806 cycles -> exactly one frame_start pulse per frame; horiz_sync low for 136 cycles per line; vert_sync low for 6 lines.
REQ-033 PIPE_DELAY=1, pix_en=1 -> video_on falls exactly 2 clk after pixel_column is loaded with 1024; pixel_column 1343 is followed by 0 with pixel_row incremented.
REQ-034 pix_en toggling 1,0,1,0 -> each coordinate is held for 2 clk; sync widths double in clk count; frame_start is never longer than 1 clk.
REQ-035 Corner wrap (1343,805) with pix_en=1 -> next output (0,0), frame_start=1, vert_sync inactive.
REQ-036 Reset asserted at (500,400) -> next clk outputs (0,0), video_on=0, syncs inactive; counting restarts cleanly.
REQ-037 SYNC_POL=1 build -> syncs idle low and pulse high with identical timing.
